// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM path: capture FSM encoding, default counter
// width and the 7-bit timer/compare width used by the PWM output block.
package pwm_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int PWM_CTR_W = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } state_t;

endpackage

// File: rtl/pwm_in_sync.sv
// Synchronizer for the asynchronous PWM input plus one-cycle delayed copy and
// edge strobes; sync_ready marks when the pipeline holds genuine samples.
module pwm_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic srst,
  input  logic pwm_in,
  output logic level,
  output logic rise,
  output logic fall,
  output logic sync_ready
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] sync_next;
  logic                   s_d_reg;
  logic [SYNC_STAGES:0]   fill_reg;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign sync_next[gi] = pwm_in;
      end else begin : g_rest
        assign sync_next[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  // fill_reg tracks how far fresh samples have propagated since reset, so a
  // level that was already high is not mistaken for a low-to-high transition.
  always_ff @(posedge clk) begin
    if (srst) begin
      sync_reg <= '0;
      s_d_reg  <= 1'b0;
      fill_reg <= '0;
    end else begin
      sync_reg <= sync_next;
      s_d_reg  <= sync_reg[SYNC_STAGES-1];
      fill_reg <= {fill_reg[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign level      = sync_reg[SYNC_STAGES-1];
  assign rise       = level & ~s_d_reg;
  assign fall       = ~level & s_d_reg;
  assign sync_ready = fill_reg[SYNC_STAGES];

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and rising-to-rising period of an asynchronous PWM input,
// with back-to-back period capture and a saturating-count timeout.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PWM_IN,
  output logic [CNT_W-1:0] DUTY,
  output logic [CNT_W-1:0] PERIOD,
  output logic             VALID,
  output logic             ERR,
  output logic             LEVEL
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic s, rise, fall, sync_ready;

  pwm_in_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (CLK),
    .srst      (RST),
    .pwm_in    (PWM_IN),
    .level     (s),
    .rise      (rise),
    .fall      (fall),
    .sync_ready(sync_ready)
  );

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] hcnt_reg, hcnt_next;
  logic [CNT_W-1:0] pcnt_reg, pcnt_next;
  logic [CNT_W-1:0] duty_reg, duty_next;
  logic [CNT_W-1:0] period_reg, period_next;
  logic             valid_reg, valid_next;
  logic             err_reg, err_next;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg  <= IDLE;
      hcnt_reg   <= '0;
      pcnt_reg   <= '0;
      duty_reg   <= '0;
      period_reg <= '0;
      valid_reg  <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      hcnt_reg   <= hcnt_next;
      pcnt_reg   <= pcnt_next;
      duty_reg   <= duty_next;
      period_reg <= period_next;
      valid_reg  <= valid_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    hcnt_next   = hcnt_reg;
    pcnt_next   = pcnt_reg;
    duty_next   = duty_reg;
    period_next = period_reg;
    valid_next  = 1'b0;
    err_next    = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (sync_ready && !s) state_next = ARMED;
      end
      ARMED: begin
        if (rise) begin
          hcnt_next  = CNT_ONE;
          pcnt_next  = CNT_ONE;
          state_next = HIGH;
        end
      end
      HIGH: begin
        // hcnt never exceeds pcnt, so only pcnt needs the saturation guard
        if (pcnt_reg == CNT_MAX) begin
          err_next   = 1'b1;
          hcnt_next  = '0;
          pcnt_next  = '0;
          state_next = IDLE;
        end else begin
          pcnt_next = pcnt_reg + CNT_ONE;
          if (s) hcnt_next = hcnt_reg + CNT_ONE;
          if (fall) state_next = LOW;
        end
      end
      LOW: begin
        if (rise) begin
          duty_next   = hcnt_reg;
          period_next = pcnt_reg;
          valid_next  = 1'b1;
          hcnt_next   = CNT_ONE;
          pcnt_next   = CNT_ONE;
          state_next  = HIGH;
        end else if (pcnt_reg == CNT_MAX) begin
          err_next   = 1'b1;
          hcnt_next  = '0;
          pcnt_next  = '0;
          state_next = IDLE;
        end else begin
          pcnt_next = pcnt_reg + CNT_ONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign DUTY   = duty_reg;
  assign PERIOD = period_reg;
  assign VALID  = valid_reg;
  assign ERR    = err_reg;
  assign LEVEL  = s;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: expected DUTY/PERIOD/arrival cycle queued
// at each driven rising edge, popped and compared on VALID.
module tb_pwm_capture;
  import pwm_pkg::*;

  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             pwm_in;
  logic [CNT_W-1:0] duty;
  logic [CNT_W-1:0] period;
  logic             valid;
  logic             err;
  logic             level;

  pwm_capture #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(2)
  ) dut (
    .CLK   (clk),
    .RST   (rst),
    .PWM_IN(pwm_in),
    .DUTY  (duty),
    .PERIOD(period),
    .VALID (valid),
    .ERR   (err),
    .LEVEL (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int duty;
    int period;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   cyc       = 0;
  int   err_count = 0;
  int   err_cyc   = -1;
  int   last_rise = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: one line per VALID transaction.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid) begin
        $display("cycle %0d VALID duty=%0d period=%0d", cyc, duty, period);
        check_eq("duty_le_period", int'(duty <= period), 1);
        check_eq("valid_err_excl", int'(err), 0);
        if (sb.size() == 0) begin
          check_eq("unexpected_valid", sb.size(), 1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_eq("duty", int'(duty), e.duty);
          check_eq("period", int'(period), e.period);
          check_eq("valid_cycle", cyc, e.cyc);
        end
      end
      if (err) begin
        $display("cycle %0d ERR", cyc);
        err_count++;
        err_cyc = cyc;
      end
    end
  end

  task automatic tick(input logic v);
    @(negedge clk);
    pwm_in = v;
  endtask

  task automatic hold(input logic v, input int n);
    repeat (n) tick(v);
  endtask

  task automatic do_reset(input logic lvl);
    @(negedge clk);
    rst    = 1'b1;
    pwm_in = lvl;
    repeat (3) @(negedge clk);
    rst       = 1'b0;
    err_count = 0;
    err_cyc   = -1;
  endtask

  // n full periods followed by one more rising edge held for final_h cycles;
  // every rising edge after the first completes a period.
  task automatic drive_train(input int h, input int l, input int n, input int final_h);
    for (int i = 0; i <= n; i++) begin
      tick(1'b1);
      last_rise = cyc;
      if (i > 0) sb.push_back('{duty: h, period: h + l, cyc: cyc + 3});
      if (i < n) begin
        hold(1'b1, h - 1);
        hold(1'b0, l);
      end else begin
        hold(1'b1, final_h - 1);
      end
    end
  endtask

  task automatic drain(input string tag);
    hold(1'b0, 10);
    check_eq(tag, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    logic [PWM_CTR_W-1:0] tcr;
    logic [PWM_CTR_W-1:0] ccr;
    bit                   first;
    int                   err_exp;

    rst    = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_duty", int'(duty), 0);
    check_eq("rst_period", int'(period), 0);
    check_eq("rst_valid", int'(valid), 0);
    check_eq("rst_err", int'(err), 0);
    check_eq("rst_level", int'(level), 0);
    check_eq("rst_state", int'(dut.state_reg), int'(IDLE));
    rst = 1'b0;

    // Steady 20 high / 108 low
    hold(1'b0, 10);
    drive_train(20, 108, 4, 20);
    check_eq("steady_err_cnt", err_count, 0);
    drain("steady_drain");

    // Loopback from a 7-bit free-running timer, compare at 64
    do_reset(1'b0);
    hold(1'b0, 10);
    tcr   = 7'd64;
    ccr   = 7'd64;
    first = 1'b1;
    for (int i = 0; i < 581; i++) begin
      tick(tcr < ccr);
      if (tcr == 7'd0) begin
        if (!first) sb.push_back('{duty: 64, period: 128, cyc: cyc + 3});
        first = 1'b0;
      end
      tcr = tcr + 7'd1;
    end
    check_eq("loop_err_cnt", err_count, 0);
    drain("loop_drain");

    // Input high through reset release
    do_reset(1'b1);
    hold(1'b1, 300);
    check_eq("held_err_cnt", err_count, 0);
    check_eq("held_level", int'(level), 1);
    check_eq("held_state", int'(dut.state_reg), int'(IDLE));
    hold(1'b0, 40);
    drive_train(20, 108, 1, 20);
    drain("held_drain");

    // Stuck high after a completed period -> single timeout
    do_reset(1'b0);
    hold(1'b0, 10);
    drive_train(30, 70, 1, 300);
    err_exp = last_rise + 3 + 255;
    hold(1'b0, 10);
    check_eq("tmo_err_cnt", err_count, 1);
    check_eq("tmo_err_cycle", err_cyc, err_exp);
    check_eq("tmo_duty_kept", int'(duty), 30);
    check_eq("tmo_period_kept", int'(period), 100);
    drain("tmo_drain");

    // Reset pulse in the middle of a high phase
    do_reset(1'b0);
    hold(1'b0, 10);
    tick(1'b1);
    hold(1'b1, 9);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    hold(1'b1, 10);
    hold(1'b0, 80);
    drive_train(20, 80, 1, 20);
    check_eq("midrst_err_cnt", err_count, 0);
    drain("midrst_drain");

    // Isolated single-cycle pulses
    do_reset(1'b0);
    hold(1'b0, 10);
    drive_train(1, 49, 3, 1);
    check_eq("glitch_err_cnt", err_count, 0);
    drain("glitch_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter CNT_W, default 8: width of all measurement counters and outputs, sized for the 128-cycle PWM period.
REQ-002 Parameter SYNC_STAGES, default 2: number of flops in the PWM_IN synchronizer, minimum 2.
REQ-003 CLK  input  1  system clock; all state updates on rising edge.
REQ-004 RST  input  1  synchronous reset, active-high.
REQ-005 PWM_IN  input  1  asynchronous PWM waveform to be measured (motor control signal or external source).
REQ-006 DUTY  output  CNT_W  high-time, in CLK cycles, of the last complete period.
REQ-007 PERIOD  output  CNT_W  rising-edge-to-rising-edge length, in CLK cycles, of the last complete period.
REQ-008 VALID  output  1  one-cycle pulse: DUTY/PERIOD updated this cycle.
REQ-009 ERR  output  1  one-cycle pulse: timeout (no rising edge within 2^CNT_W-1 cycles).
REQ-010 LEVEL  output  1  synchronized PWM_IN level (last synchronizer stage).

Function
REQ-011 PWM_IN SHALL pass through SYNC_STAGES flops; S is the last stage, S_D is S delayed one cycle; RISE = S & ~S_D; FALL = ~S & S_D.
REQ-012 FSM states: IDLE, ARMED, HIGH, LOW.
REQ-013 IDLE: when S = 0, go to ARMED; a level already high after reset SHALL never be treated as a rising edge.
REQ-014 ARMED: on RISE, set HCNT = 1 and PCNT = 1, then go to HIGH.
REQ-015 HIGH: every cycle PCNT += 1; HCNT += 1 while S = 1; on FALL, hold HCNT and go to LOW.
REQ-016 LOW: every cycle PCNT += 1; on RISE, latch DUTY = HCNT and PERIOD = PCNT, pulse VALID, reload HCNT = 1 and PCNT = 1, and stay in measurement (go to HIGH, back-to-back periods, no dead cycle).
REQ-017 VALID latency: VALID SHALL assert in the cycle RISE is detected, i.e. SYNC_STAGES+1 CLK edges after the PWM_IN rising edge.
REQ-018 Timeout: if PCNT = 2^CNT_W-1 in HIGH or LOW with no RISE, pulse ERR, clear HCNT and PCNT, go to IDLE, and leave DUTY/PERIOD unchanged.
REQ-019 Counters SHALL never wrap; timeout takes priority over increment.
REQ-020 A one-cycle glitch on S SHALL be measured as-is (HCNT = 1 if isolated high); there is no debouncing.
REQ-021 DUTY <= PERIOD SHALL hold at every VALID.
REQ-022 VALID and ERR SHALL never assert in the same cycle.

Reset
REQ-023 While RST = 1: state = IDLE, synchronizer flops = 0, S_D = 0, HCNT = PCNT = 0, DUTY = PERIOD = 0, VALID = ERR = 0.
REQ-024 RST asserted mid-measurement SHALL discard the partial period; the first VALID after release requires ARMED, a full high phase, and the next RISE.

Structure
REQ-025 Shared package pwm_pkg SHALL hold the FSM state encoding and the default CNT_W; the 7-bit TCR/CCR width already used by the PWM output path also goes there.
REQ-026 One sub-module, pwm_in_sync, SHALL implement the synchronizer plus S_D, RISE and FALL; the counters and FSM stay in pwm_capture.

Verification
REQ-027 Steady PWM, 20 cycles high / 108 low (period 128): from the second rising edge on, every VALID shows DUTY = 20, PERIOD = 128, spaced 128 cycles apart, with ERR never asserted.
REQ-028 Loopback from the PWM output block with CCR = 64 and a free-running 7-bit TCR: DUTY = 64, PERIOD = 128.
REQ-029 PWM_IN held high through reset release: no VALID; after 300 cycles still high, state IDLE, no ERR; the first VALID comes only after a low phase followed by a full period.
REQ-030 PWM_IN goes high and stays high for 300 cycles after ARMED: ERR pulses exactly once, 255 cycles after RISE; DUTY/PERIOD keep their prior values.
REQ-031 RST pulsed for 1 cycle at cycle 10 of a high phase (20 high / 80 low): no VALID for the aborted period; the next full period reports DUTY = 20, PERIOD = 100.
REQ-032 Isolated 1-cycle high pulses every 50 cycles: DUTY = 1, PERIOD = 50.
